// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline: load-use interlock, redirect flush,
// data-memory wait with timeout/halt. Optional performance counters under PIPE_PERF_EN.
module pipeline_ctrl #(
    parameter int NUM_REGS    = 32,
    parameter int REG_SEL     = $clog2(NUM_REGS),
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_SEL-1:0] id_rs1,
    input  logic [REG_SEL-1:0] id_rs2,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic               ex_mem_read,
    input  logic [REG_SEL-1:0] ex_rd,
    input  logic               ex_redirect,
    input  logic               mem_req,
    input  logic               mem_ready,
    output logic               pc_stall,
    output logic               ifid_stall,
    output logic               idex_stall,
    output logic               exmem_stall,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               mem_fault,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_count
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  wait_q, wait_d;
    logic           fault_q, fault_d;
    logic           freeze_s;
    logic           load_use_s;
    logic [CW-1:0]  wait_inc_s;

    assign freeze_s   = (state_q != HALT) && mem_req && !mem_ready;
    assign wait_inc_s = wait_q + CW'(1);
    assign load_use_s = ex_mem_read && (ex_rd != {REG_SEL{1'b0}}) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign mem_fault  = fault_q;

    // Next-state logic: the wait counter tracks consecutive frozen cycles, the first counted in RUN
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        case (state_q)
            RUN: begin
                if (freeze_s) begin
                    state_d = MEM_WAIT;
                    wait_d  = CW'(1);
                end else begin
                    wait_d  = {CW{1'b0}};
                end
            end
            MEM_WAIT: begin
                if (!freeze_s) begin
                    state_d = RUN;
                    wait_d  = {CW{1'b0}};
                end else if (wait_inc_s == CW'(MEM_TIMEOUT)) begin
                    state_d = HALT;
                    wait_d  = wait_inc_s;
                    fault_d = 1'b1;
                end else begin
                    wait_d  = wait_inc_s;
                end
            end
            HALT: begin
                state_d = HALT;
                fault_d = 1'b1;
            end
            default: begin
                state_d = HALT;
                fault_d = 1'b1;
            end
        endcase
    end

    // FSM state, wait counter and sticky fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= {CW{1'b0}};
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    // Stall/flush decode in priority order: reset, halt, freeze, redirect, load-use
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        if (rst) begin
            pc_stall = 1'b0;
        end else if ((state_q == HALT) || freeze_s) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use_s) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end else begin
            pc_stall = 1'b0;
        end
    end

`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        any_stall_s;

    assign any_stall_s  = pc_stall | ifid_stall | idex_stall | exmem_stall;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

    // Free-running wrap-around performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {31'd0, any_stall_s};
            flush_cnt_q <= flush_cnt_q + {31'd0, idex_flush};
        end
    end
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_ctrl;

    localparam int RS = 5;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [RS-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic          ex_mem_read = 1'b0, ex_redirect = 1'b0;
    logic          mem_req = 1'b0, mem_ready = 1'b0;
    logic          pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic          ifid_flush, idex_flush, mem_fault;
    logic [31:0]   stall_cycles, flush_count;
    logic [5:0]    obs;

    int pass_cnt = 0;
    int total_cnt = 0;

    // model state
    int          m_wait;
    bit          m_halt;
    int unsigned m_stall, m_flush;

    pipeline_ctrl #(.NUM_REGS(32), .REG_SEL(RS), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idex_stall(idex_stall), .exmem_stall(exmem_stall),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .mem_fault(mem_fault),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign obs = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush};

    function automatic logic [5:0] m_expect();
        bit hit;
        hit = ex_mem_read && (ex_rd != 0) &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (rst) return 6'b000000;
        if (m_halt || (mem_req && !mem_ready)) return 6'b111100;
        if (ex_redirect) return 6'b000011;
        if (hit) return 6'b110001;
        return 6'b000000;
    endfunction

    function automatic void m_tick();
        logic [5:0] e;
        e = m_expect();
        if (e[5:2] != 4'b0000) m_stall++;
        if (e[0]) m_flush++;
        if (!m_halt) begin
            if (mem_req && !mem_ready) begin
                m_wait++;
                if (m_wait == TMO) m_halt = 1'b1;
            end else begin
                m_wait = 0;
            end
        end
    endfunction

    function automatic void m_reset();
        m_wait = 0; m_halt = 1'b0; m_stall = 0; m_flush = 0;
    endfunction

    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_load_use(input logic [RS-1:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_idle();
        mem_req = 1'b1; mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (obs !== 6'b000000) $display("FAIL reset_outputs obs=%b exp=000000", obs);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (mem_fault !== 1'b0 || stall_cycles !== 32'd0 || flush_count !== 32'd0)
            $display("FAIL reset_state fault=%b stall=%0d flush=%0d exp=0/0/0",
                     mem_fault, stall_cycles, flush_count);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0; set_idle();
        m_reset();
        #1;
        total_cnt++;
        if (obs !== 6'b000000) $display("FAIL idle_outputs obs=%b exp=000000", obs);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(5'd5);
        #1;
        total_cnt++;
        if (obs !== 6'b110001) $display("FAIL load_use_hit obs=%b exp=110001", obs);
        else pass_cnt++;
        @(negedge clk);
        ex_mem_read = 1'b0;
        #1;
        total_cnt++;
        if (obs !== 6'b000000) $display("FAIL load_use_clear obs=%b exp=000000", obs);
        else pass_cnt++;
        @(negedge clk);
        set_load_use(5'd0);
        id_rs1 = 5'd0;
        #1;
        total_cnt++;
        if (obs !== 6'b000000) $display("FAIL rd_zero obs=%b exp=000000", obs);
        else pass_cnt++;
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_redirect_priority();
        logic [31:0] exp_s, exp_f;
        do_reset();
        set_load_use(5'd5);
        @(negedge clk);
        ex_mem_read = 1'b0;
        @(negedge clk);
        set_load_use(5'd5);
        ex_redirect = 1'b1;
        #1;
        total_cnt++;
        if (obs !== 6'b000011) $display("FAIL redirect_over_load_use obs=%b exp=000011", obs);
        else pass_cnt++;
        @(negedge clk);
        set_idle();
`ifdef PIPE_PERF_EN
        exp_s = 32'd1; exp_f = 32'd2;
`else
        exp_s = 32'd0; exp_f = 32'd0;
`endif
        #1;
        total_cnt++;
        if (stall_cycles !== exp_s || flush_count !== exp_f)
            $display("FAIL perf_counters stall=%0d flush=%0d exp=%0d/%0d",
                     stall_cycles, flush_count, exp_s, exp_f);
        else pass_cnt++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (obs !== 6'b111100) $display("FAIL mem_wait_freeze[%0d] obs=%b exp=111100", i, obs);
            else pass_cnt++;
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        total_cnt++;
        if (obs !== 6'b000011) $display("FAIL mem_ready_release obs=%b exp=000011", obs);
        else pass_cnt++;
        @(negedge clk);
        set_idle();
        set_load_use(5'd5);
        #1;
        total_cnt++;
        if (obs !== 6'b110001 || mem_fault !== 1'b0)
            $display("FAIL after_wait_run obs=%b fault=%b exp=110001/0", obs, mem_fault);
        else pass_cnt++;
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (obs !== 6'b000000 || mem_fault !== 1'b0)
            $display("FAIL reset_mid_wait obs=%b fault=%b exp=000000/0", obs, mem_fault);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (mem_fault !== 1'b0 || obs !== 6'b111100)
            $display("FAIL pre_timeout fault=%b obs=%b exp=0/111100", mem_fault, obs);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (mem_fault !== 1'b1) $display("FAIL timeout_fault fault=%b exp=1", mem_fault);
        else pass_cnt++;
        mem_req = 1'b0; mem_ready = 1'b1; ex_redirect = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total_cnt++;
        if (obs !== 6'b111100 || mem_fault !== 1'b1)
            $display("FAIL halt_sticky obs=%b fault=%b exp=111100/1", obs, mem_fault);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (obs !== 6'b000000 || mem_fault !== 1'b0)
            $display("FAIL halt_reset obs=%b fault=%b exp=000000/0", obs, mem_fault);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0; set_idle();
        m_reset();
        #1;
        total_cnt++;
        if (obs !== 6'b000000) $display("FAIL post_halt_idle obs=%b exp=000000", obs);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [5:0]  e;
        logic [31:0] es, ef;
        int errs = 0;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            id_rs1 = RS'($urandom_range(0, 3));
            id_rs2 = RS'($urandom_range(0, 3));
            ex_rd = RS'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom);
            id_uses_rs2 = 1'($urandom);
            ex_mem_read = 1'($urandom);
            ex_redirect = ($urandom_range(0, 3) == 0);
            mem_req = ($urandom_range(0, 3) == 0);
            mem_ready = (m_wait >= 10) ? 1'b1 : 1'($urandom);
            #1;
            e = m_expect();
`ifdef PIPE_PERF_EN
            es = m_stall; ef = m_flush;
`else
            es = 32'd0; ef = 32'd0;
`endif
            total_cnt++;
            if (obs !== e || stall_cycles !== es || flush_count !== ef || mem_fault !== m_halt) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random[%0d] obs=%b exp=%b stall=%0d/%0d flush=%0d/%0d fault=%b/%b",
                             n, obs, e, stall_cycles, es, flush_count, ef, mem_fault, m_halt);
            end else pass_cnt++;
            @(posedge clk);
            m_tick();
            @(negedge clk);
        end
        set_idle();
    endtask

    initial begin
        m_reset();
        test_reset();
        test_load_use();
        test_redirect_priority();
        test_mem_wait();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001: Parameter NUM_REGS, default 32, number of architectural registers.
REQ-002: Parameter REG_SEL, default $clog2(NUM_REGS), register-select width.
REQ-003: Parameter MEM_TIMEOUT, default 16, maximum data-memory wait cycles before fault.
REQ-004: clk  in  1  single clock; all state updates on rising edge.
REQ-005: rst  in  1  reset, asynchronous, active-high.
REQ-006: id_rs1, id_rs2  in  REG_SEL each  source selects of the instruction in ID.
REQ-007: id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source.
REQ-008: ex_mem_read  in  1  instruction in EX is a load.
REQ-009: ex_rd  in  REG_SEL  destination of the instruction in EX.
REQ-010: ex_redirect  in  1  EX resolved a taken branch or a jump.
REQ-011: mem_req, mem_ready  in  1 each  MEM-stage access pending / data memory ready.
REQ-012: pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold that pipeline register.
REQ-013: ifid_flush, idex_flush  out  1 each  load NOP into that pipeline register.
REQ-014: mem_fault  out  1  sticky data-memory timeout error.
REQ-015: stall_cycles, flush_count  out  32 each  performance counters.

Function
REQ-016: FSM states RUN, MEM_WAIT, HALT; state and wait counter registered; stall/flush outputs combinational from state and inputs.
REQ-017: freeze = (state RUN or MEM_WAIT) and mem_req and not mem_ready; freeze asserts all four stall outputs, no flushes.
REQ-018: RUN -> MEM_WAIT when freeze; wait counter loaded with 1.
REQ-019: MEM_WAIT: counter increments each frozen cycle; mem_ready -> RUN, counter cleared, stalls drop in the same cycle mem_ready rises.
REQ-020: MEM_WAIT -> HALT when counter reaches MEM_TIMEOUT with mem_ready still low; mem_fault set.
REQ-021: HALT: all stalls asserted, all flushes deasserted, mem_fault held 1; exits only via rst.
REQ-022: Redirect, RUN and not freeze: ex_redirect -> ifid_flush=1, idex_flush=1 for one cycle, no stalls.
REQ-023: Load-use, RUN, no freeze, no redirect: ex_mem_read and ex_rd!=0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)) -> pc_stall=1, ifid_stall=1, idex_flush=1 for one cycle.
REQ-024: Priority: HALT > freeze > redirect > load-use; redirect with load-use hit produces flushes only.
REQ-025: ex_rd==0 never produces a load-use stall.
REQ-026: Redirect or load-use during freeze is ignored; the held inputs are re-evaluated the cycle freeze clears.
REQ-027: No hazard, RUN, no freeze: all stall/flush outputs 0.

Reset
REQ-028: rst asserted, at any point including mid-MEM_WAIT: state RUN, wait counter 0, mem_fault 0, counters 0, all stall/flush outputs 0 while rst is high.

Configuration
REQ-029: Macro PIPE_PERF_EN defined: stall_cycles increments each cycle any stall output is 1; flush_count increments each cycle idex_flush is 1; both wrap modulo 2^32.
REQ-030: PIPE_PERF_EN undefined: ports remain, both driven constant 0, no counter flops.

Verification
REQ-031: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle pc_stall=ifid_stall=idex_flush=1, then all 0 once ex_mem_read=0.
REQ-032: Same with ex_rd=0 -> no stall, no flush.
REQ-033: ex_redirect=1 together with load-use hit -> ifid_flush=idex_flush=1, pc_stall=0.
REQ-034: mem_req=1, mem_ready low 3 cycles, then 1 -> four stalls high 3 cycles, low on mem_ready cycle, state RUN, mem_fault=0.
REQ-035: mem_req=1, mem_ready held low -> HALT after 16 wait cycles, mem_fault=1 sticky; rst pulse -> mem_fault=0, outputs 0.
REQ-036: PIPE_PERF_EN defined, REQ-031 then REQ-033 -> stall_cycles=1, flush_count=2; undefined -> both 0.
